fetch_pc_unit: RTL

//  IF stage and IF/ID pipeline register. Holds the PC and fetches from the instruction cache
//  (variable latency). Computes branch/jump targets from the ID-stage instruction and applies
//  the taken/not-taken decision (pc_sel, is_bj) produced by the ID-stage branch resolver.

---
 rtl/fetch_pc_unit_if.sv | 10 +
 rtl/fetch_pc_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - instruction-cache fetch port between the IF stage and the I-cache
interface fetch_pc_unit_if;
  logic        req;
  logic [15:0] addr;
  logic [15:0] data;
  logic        ready;

  modport master (output req, addr, input data, ready);
  modport slave  (input req, addr, output data, ready);
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF stage PC, I-cache fetch and IF/ID register with branch redirect
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OPC = 5'b00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  pc_sel,
  input  logic                  is_bj,
  input  logic [15:0]           id_rs,
  fetch_pc_unit_if.master       imem,
  output logic [15:0]           ifid_instr,
  output logic [15:0]           ifid_pc_plus2,
  output logic                  ifid_valid,
  output logic                  flush_id,
  output logic                  halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]           perf_redirects,
  output logic [15:0]           perf_bubbles
`endif
);

  typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] pend, pend_n;
  logic [15:0] instr_n, pp2_n;
  logic        valid_n;
  logic        take, hlt;
  logic [15:0] target;
  logic [15:0] sext8, sext11;
  logic [4:0]  opc;

  assign opc    = ifid_instr[15:11];
  assign sext8  = {{8{ifid_instr[7]}}, ifid_instr[7:0]};
  assign sext11 = {{5{ifid_instr[10]}}, ifid_instr[10:0]};

  assign take     = ifid_valid & is_bj & pc_sel & ~stall;
  assign hlt      = ifid_valid & ~stall & (opc == HALT_OPC) & ~take;
  assign flush_id = take;
  assign halted   = (state == HALT);
  assign imem.req  = (state != HALT);
  assign imem.addr = pc;

  // Conditional branches and PC-relative jumps use the link value as base; JR/JALR use Rs.
  always_comb begin
    casez (opc)
      5'b011??: target = ifid_pc_plus2 + sext8;
      5'b001?0: target = ifid_pc_plus2 + sext11;
      5'b001?1: target = id_rs + sext8;
      default:  target = ifid_pc_plus2 + sext8;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend;
    instr_n = ifid_instr;
    pp2_n   = ifid_pc_plus2;
    valid_n = ifid_valid;
    case (state)
      FETCH: begin
        if (hlt) begin
          state_n = HALT;
          valid_n = 1'b0;
        end else if (take) begin
          valid_n = 1'b0;
          if (imem.ready) begin
            pc_n = target;
          end else begin
            pend_n  = target;
            state_n = DRAIN;
          end
        end else if (stall) begin
          valid_n = ifid_valid;
        end else if (imem.ready) begin
          instr_n = imem.data;
          pp2_n   = pc + 16'd2;
          valid_n = 1'b1;
          pc_n    = pc + 16'd2;
        end else begin
          valid_n = 1'b0;
        end
      end
      // The outstanding wrong-path miss must complete before the redirected fetch can issue.
      DRAIN: begin
        if (imem.ready) begin
          pc_n    = pend;
          state_n = FETCH;
        end
      end
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      pend          <= RESET_PC;
      ifid_instr    <= 16'h0000;
      ifid_pc_plus2 <= 16'h0000;
      ifid_valid    <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      pend          <= pend_n;
      ifid_instr    <= instr_n;
      ifid_pc_plus2 <= pp2_n;
      ifid_valid    <= valid_n;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_redirects <= 16'h0000;
      perf_bubbles   <= 16'h0000;
    end else if (state != HALT) begin
      if (take)
        perf_redirects <= perf_redirects + 16'd1;
      if (!ifid_valid)
        perf_bubbles <= perf_bubbles + 16'd1;
    end
  end
`endif

endmodule
